// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce bank and its per-channel slices.
package debounce_pkg;

    localparam int unsigned DEFAULT_WAIT = 32'(23'd4999999);
    localparam int unsigned MAX_CHANNELS = 32;

    // Qualification strobes a channel raises one cycle before its registered pulses.
    typedef struct packed {
        logic rise;
        logic fall;
    } pulse_t;

    // Ceiling log2; callers always pass values of at least 2.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce slice: two-flop synchroniser, saturating stability counter,
// registered debounced level and single-cycle edge pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned WAIT     = DEFAULT_WAIT,
    parameter bit          INV      = 1'b0,
    parameter bit          RST_VAL  = 1'b0,
    parameter bit          USE_TICK = 1'b0
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   in,
    input  logic   tick,
    output logic   out,
    output logic   rise,
    output logic   fall,
    output pulse_t pulse_c
);

    localparam int unsigned CNT_W = clog2(WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT);

    logic             sync_0;
    logic             sync_1;
    logic [CNT_W-1:0] cnt;
    logic             cnt_en;
    logic             qualify;

    // Load the debounced level once the synchronised value has been stable long enough.
    always_comb begin
        cnt_en       = 1'b0;
        qualify      = 1'b0;
        pulse_c      = '0;
        cnt_en       = !USE_TICK || tick;
        qualify      = (cnt == CNT_MAX) && (sync_1 != out);
        pulse_c.rise = qualify && sync_1;
        pulse_c.fall = qualify && !sync_1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_0 <= RST_VAL;
            sync_1 <= RST_VAL;
            cnt    <= '0;
            out    <= RST_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_0 <= in ^ INV;
            sync_1 <= sync_0;
            // A toggle restarts the count even on a tick cycle.
            if (sync_0 != sync_1) begin
                cnt <= '0;
            end else if (cnt_en && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (qualify) begin
                out <= sync_1;
            end
            rise <= pulse_c.rise;
            fall <= pulse_c.fall;
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels with a shared change strobe.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned   N        = 4,
    parameter int unsigned   WAIT     = DEFAULT_WAIT,
    parameter logic [N-1:0]  INV_MASK = '0,
    parameter logic [N-1:0]  RST_VAL  = '0,
    parameter bit            USE_TICK = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in,
    input  logic         tick,
    output logic [N-1:0] out,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         any_change
);

    pulse_t       pulse_c [N];
    logic [N-1:0] change_c;

    for (genvar i = 0; i < N; i++) begin : g_chan
        debounce_channel #(
            .WAIT     (WAIT),
            .INV      (INV_MASK[i]),
            .RST_VAL  (RST_VAL[i]),
            .USE_TICK (USE_TICK)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .in      (in[i]),
            .tick    (tick),
            .out     (out[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .pulse_c (pulse_c[i])
        );
        assign change_c[i] = pulse_c[i].rise | pulse_c[i].fall;
    end

    // Registered from the same strobes as rise/fall so it lands in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            any_change <= 1'b0;
        end else begin
            any_change <= |change_c;
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: three configurations, expected edges queued from latency rules.
module tb_debounce_bank;

    localparam int unsigned N    = 4;
    localparam int unsigned WAIT = 7;
    localparam int          ND   = 3;

    typedef struct {
        int cyc;
        int dut;
        int ch;
        bit is_rise;
    } evt_t;

    logic         clk = 1'b0;
    logic         reset_v [ND];
    logic         tick_v  [ND];
    logic [N-1:0] in_v    [ND];
    logic [N-1:0] out_v   [ND];
    logic [N-1:0] rise_v  [ND];
    logic [N-1:0] fall_v  [ND];
    logic         any_v   [ND];

    evt_t         sb [$];
    logic [N-1:0] exp_out [ND];
    int           cyc    = 0;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    debounce_bank #(.N(N), .WAIT(WAIT), .INV_MASK(4'b0000), .RST_VAL(4'b0000), .USE_TICK(1'b0)) dut_a (
        .clk(clk), .reset(reset_v[0]), .in(in_v[0]), .tick(tick_v[0]),
        .out(out_v[0]), .rise(rise_v[0]), .fall(fall_v[0]), .any_change(any_v[0]));

    debounce_bank #(.N(N), .WAIT(WAIT), .INV_MASK(4'b0000), .RST_VAL(4'b0000), .USE_TICK(1'b1)) dut_t (
        .clk(clk), .reset(reset_v[1]), .in(in_v[1]), .tick(tick_v[1]),
        .out(out_v[1]), .rise(rise_v[1]), .fall(fall_v[1]), .any_change(any_v[1]));

    debounce_bank #(.N(N), .WAIT(WAIT), .INV_MASK(4'b0001), .RST_VAL(4'b0000), .USE_TICK(1'b0)) dut_i (
        .clk(clk), .reset(reset_v[2]), .in(in_v[2]), .tick(tick_v[2]),
        .out(out_v[2]), .rise(rise_v[2]), .fall(fall_v[2]), .any_change(any_v[2]));

    task automatic expect_evt(input int c, input int d, input int ch, input bit r);
        sb.push_back('{cyc: c, dut: d, ch: ch, is_rise: r});
    endtask

    task automatic check_cycle();
        for (int d = 0; d < ND; d++) begin
            logic [N-1:0] er;
            logic [N-1:0] ef;
            logic         ea;
            er = '0;
            ef = '0;
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].cyc == cyc && sb[k].dut == d) begin
                    if (sb[k].is_rise) er[sb[k].ch] = 1'b1;
                    else               ef[sb[k].ch] = 1'b1;
                    sb.delete(k);
                end
            end
            exp_out[d] = (exp_out[d] | er) & ~ef;
            ea = |(er | ef);
            checks++;
            assert (out_v[d] === exp_out[d]) else begin
                errors++;
                $error("FAIL out dut%0d cyc%0d: got %b exp %b", d, cyc, out_v[d], exp_out[d]);
            end
            checks++;
            assert (rise_v[d] === er) else begin
                errors++;
                $error("FAIL rise dut%0d cyc%0d: got %b exp %b", d, cyc, rise_v[d], er);
            end
            checks++;
            assert (fall_v[d] === ef) else begin
                errors++;
                $error("FAIL fall dut%0d cyc%0d: got %b exp %b", d, cyc, fall_v[d], ef);
            end
            checks++;
            assert (any_v[d] === ea) else begin
                errors++;
                $error("FAIL any_change dut%0d cyc%0d: got %b exp %b", d, cyc, any_v[d], ea);
            end
        end
    endtask

    // Advance n edges, checking every DUT after each one, then drive the next tick values.
    task automatic step(input int n);
        for (int s = 0; s < n; s++) begin
            @(posedge clk);
            #1;
            cyc++;
            check_cycle();
            tick_v[0] = 1'($urandom_range(0, 1));
            tick_v[1] = ((cyc + 1) % 4 == 0);
            tick_v[2] = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        int t;
        int n_ticks;
        int k;

        for (int d = 0; d < ND; d++) begin
            reset_v[d] = 1'b0;
            tick_v[d]  = 1'b0;
            in_v[d]    = '0;
            exp_out[d] = '0;
        end

        // All banks held in reset; outputs at reset value.
        step(3);
        reset_v[0] = 1'b1;
        step(12);

        // Single channel rises 10 edges after the input settles.
        in_v[0][0] = 1'b1;
        expect_evt(cyc + 10, 0, 0, 1'b1);
        step(14);

        // 6-cycle pulse is shorter than WAIT+1 and must vanish.
        in_v[0][1] = 1'b1;
        step(6);
        in_v[0][1] = 1'b0;
        step(15);

        // Bouncing input: only the final settled level counts.
        in_v[0][2] = 1'b1;
        step(3);
        in_v[0][2] = 1'b0;
        step(3);
        in_v[0][2] = 1'b1;
        expect_evt(cyc + 10, 0, 2, 1'b1);
        step(14);

        // Falling edge on channel 0.
        in_v[0][0] = 1'b0;
        expect_evt(cyc + 10, 0, 0, 1'b0);
        step(14);

        // Two channels qualifying together.
        in_v[0][0] = 1'b1;
        in_v[0][3] = 1'b1;
        expect_evt(cyc + 10, 0, 0, 1'b1);
        expect_evt(cyc + 10, 0, 3, 1'b1);
        step(14);

        // Tick-gated bank; toggle placed so the clearing edge coincides with a tick.
        reset_v[1] = 1'b1;
        step(12);
        while ((cyc + 2) % 4 != 0) step(1);
        in_v[1][3] = 1'b1;
        t = cyc + 2;
        n_ticks = 0;
        while (n_ticks < int'(WAIT)) begin
            t++;
            if (t % 4 == 0) n_ticks++;
        end
        expect_evt(t + 1, 1, 3, 1'b1);
        step(60);

        // Inverted channel 0 with input low: reset mid-count discards progress.
        reset_v[2] = 1'b1;
        k = cyc;
        step(7);
        reset_v[2] = 1'b0;
        step(2);
        reset_v[2] = 1'b1;
        expect_evt(k + 19, 2, 0, 1'b1);
        step(14);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: got %0d pending exp 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
